mux_2to1: RTL and testbench
===========================

Name: mux_2to1

Overview:
- Parameterised 2-to-1 selector: drives one of two equal-width data words onto its output under a single select bit.
- Provides a zero-latency combinational output and a clock-enabled registered copy with a valid flag.
- Used as the bit- or word-level building block beneath wider selectors, e.g. the 7-bit display-map selector choosing between map 0 and map 1.

Parameters:
- WIDTH, 1, data width in bits of in0, in1, out and out_q (must be >= 1).

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  asynchronous, active-high reset; clears the registered path.
- in0  input  WIDTH  data word selected when sel=0.
- in1  input  WIDTH  data word selected when sel=1.
- sel  input  1  select: 0 -> in0, 1 -> in1.
- en  input  1  capture enable for the registered path.
- out  output  WIDTH  combinational selection result.
- out_q  output  WIDTH  registered selection result.
- out_valid  output  1  high when out_q holds a captured value.

Behaviour:
- out = sel ? in1 : in0, bitwise, purely combinational, zero cycles latency.
- out is not affected by clk, rst or en.
- out follows any input change within the same delta/settling time; no glitch filtering.
- X/Z on sel: each bit of out equals in0[i] where in0[i]==in1[i]; otherwise that bit is X in simulation. No other pessimism is allowed.
- Registered path, rising clk edge with rst=0:
  - en=1: out_q <= (sel ? in1 : in0) and out_valid <= 1.
  - en=0: out_q and out_valid hold their previous values.
- Latency on the registered path is 1 cycle: a value present at edge N appears on out_q after edge N.
- Reset: rst=1 asynchronously forces out_q = 0 and out_valid = 0 immediately, independent of clk.
- Reset dominates en.
- On rst deassertion, the first rising edge with en=1 loads normally.
- Reset asserted mid-stream discards the held value; out_q stays 0 until the next enabled capture.
- sel changing in the same cycle as the enable edge: the value sampled at the edge is captured. There is no pipelining of sel separate from the data.
- No handshake back-pressure; en is a plain enable.

Decomposition:
- Shared package: a MUX_DEFAULT_WIDTH constant (1) and a DISPLAY_MAP_WIDTH constant (7) used by parents instantiating this block for 7-segment maps.
- No typedefs required.
- Sub-module: one single-bit combinational cell, mux_bit, generated WIDTH times for the out path.
- The register stage lives in mux_2to1 itself.

Test Plan:
- WIDTH=7, in0=7'b1000001, in1=7'b1100011, sel=0 -> out=7'b1000001 immediately; sel=1 -> out=7'b1100011.
- WIDTH=7, same data, rst pulse, then en=1, sel=1 for one edge -> out_q=7'b1100011 and out_valid=1 after that edge; before the edge out_q=0, out_valid=0.
- WIDTH=7, en=1, sel=0 at edge N, then en=0 and sel=1 for 3 edges -> out_q holds 7'b1000001, while out shows 7'b1100011.
- Assert rst between clock edges while out_q=7'b1100011 -> out_q=0 and out_valid=0 without waiting for clk; rst=1 with en=1 across an edge -> outputs stay 0.
- WIDTH=1 exhaustive: all 8 combinations of in0, in1, sel -> out matches the truth table; sel=X with in0=in1=1 -> out=1.
- Randomised WIDTH=7 (>=200 cycles) -> out always equals the reference select; out_q equals the previous-enabled-edge select value.

Source files
------------

// File: rtl/mux_2to1_pkg.sv
// mux_2to1_pkg
// Shared constants for the 2-to-1 selector and the blocks that instantiate it.
//   MUX_DEFAULT_WIDTH : default data width of a single selector instance.
//   DISPLAY_MAP_WIDTH : width of a 7-segment display map word, used by parents
//                       that choose between display map 0 and map 1.
package mux_2to1_pkg;

  localparam int MUX_DEFAULT_WIDTH = 1;
  localparam int DISPLAY_MAP_WIDTH = 7;

endpackage : mux_2to1_pkg

// File: rtl/mux_2to1_if.sv
// mux_2to1_if
// Groups the data, select, enable and result signals of the 2-to-1 selector.
//   in0, in1  : data words (WIDTH bits), in0 chosen when sel=0, in1 when sel=1
//   sel       : select bit
//   en        : capture enable for the registered copy
//   out       : combinational selection result
//   out_q     : registered selection result
//   out_valid : high once out_q holds a captured value
// Modports:
//   master : the side that supplies data/select/enable and reads the results
//   slave  : the selector itself
// There is no valid/ready handshake on this bus: en is a plain enable with no
// back-pressure, and every enabled rising edge captures unconditionally.
interface mux_2to1_if
  import mux_2to1_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             sel;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             out_valid;

  modport master (
    output in0,
    output in1,
    output sel,
    output en,
    input  out,
    input  out_q,
    input  out_valid
  );

  modport slave (
    input  in0,
    input  in1,
    input  sel,
    input  en,
    output out,
    output out_q,
    output out_valid
  );

endinterface : mux_2to1_if

// File: rtl/mux_2to1_bit.sv
// mux_bit
// Single-bit combinational 2-to-1 cell.
//   i_in0 : bit chosen when i_sel=0
//   i_in1 : bit chosen when i_sel=1
//   i_sel : select
//   o_out : selected bit
// The conditional operator is used on purpose: with an unknown select it
// yields the common value when i_in0 equals i_in1 and X only otherwise, so
// simulation is no more pessimistic than the real gate.
module mux_bit (
  input  logic i_in0,
  input  logic i_in1,
  input  logic i_sel,
  output logic o_out
);

  assign o_out = i_sel ? i_in1 : i_in0;

endmodule : mux_bit

// File: rtl/mux_2to1.sv
// mux_2to1
// Parameterised 2-to-1 selector with a zero-latency combinational output and
// a clock-enabled registered copy carrying a valid flag.
//   clk : rising-edge clock for the registered path
//   rst : asynchronous active-high reset, clears out_q and out_valid
//   bus : mux_2to1_if slave modport (in0, in1, sel, en -> out, out_q, out_valid)
// The combinational result does not depend on clk, rst or en. The register
// captures exactly the combinational result seen at an enabled edge, so sel
// and data are sampled together with no separate pipelining of sel.
module mux_2to1
  import mux_2to1_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  mux_2to1_if.slave bus
);

  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] r_out_q;
  logic             r_out_valid;

  // One single-bit cell per data bit keeps the X behaviour strictly bitwise.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_bit u_mux_bit (
      .i_in0 (bus.in0[i]),
      .i_in1 (bus.in1[i]),
      .i_sel (bus.sel),
      .o_out (w_sel_data[i])
    );
  end

  assign bus.out = w_sel_data;

  // Reset dominates en and discards any held value; after reset out_q stays
  // zero until the next enabled capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_q     <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.en) begin
      r_out_q     <= w_sel_data;
      r_out_valid <= 1'b1;
    end
  end

  assign bus.out_q     = r_out_q;
  assign bus.out_valid = r_out_valid;

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1
// Directed and randomised checks of mux_2to1 at WIDTH=7 and WIDTH=1.
module tb_mux_2to1;
  import mux_2to1_pkg::*;

  localparam int W = DISPLAY_MAP_WIDTH;

  logic clk;
  logic rst;

  int checks;
  int errors;

  logic [W-1:0] exp_q[$];

  mux_2to1_if #(.WIDTH(W)) bus7 ();
  mux_2to1_if #(.WIDTH(1)) bus1 ();

  mux_2to1 #(.WIDTH(W)) u_dut7 (
    .clk (clk),
    .rst (rst),
    .bus (bus7.slave)
  );

  mux_2to1 #(.WIDTH(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst      = 1'b1;
    bus7.in0 = '0;
    bus7.in1 = '0;
    bus7.sel = 1'b0;
    bus7.en  = 1'b0;
    bus1.in0 = 1'b0;
    bus1.in1 = 1'b0;
    bus1.sel = 1'b0;
    bus1.en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus7.out_q !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_out_q7 got %b want %b", bus7.out_q, 7'b0000000);
    end
    checks++;
    if (bus7.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid7 got %b want 0", bus7.out_valid);
    end
    checks++;
    if (bus1.out_q !== 1'b0 || bus1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_w1 got q=%b v=%b want q=0 v=0", bus1.out_q, bus1.out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_comb();
    @(negedge clk);
    bus7.in0 = 7'b1000001;
    bus7.in1 = 7'b1100011;
    bus7.sel = 1'b0;
    #1;
    checks++;
    if (bus7.out !== 7'b1000001) begin
      errors++;
      $display("FAIL comb_sel0 got %b want %b", bus7.out, 7'b1000001);
    end
    bus7.sel = 1'b1;
    #1;
    checks++;
    if (bus7.out !== 7'b1100011) begin
      errors++;
      $display("FAIL comb_sel1 got %b want %b", bus7.out, 7'b1100011);
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus7.en  = 1'b1;
    bus7.sel = 1'b1;
    #1;
    checks++;
    if (bus7.out_q !== 7'b0000000 || bus7.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL capture_before got q=%b v=%b want q=0000000 v=0", bus7.out_q, bus7.out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus7.out_q !== 7'b1100011 || bus7.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL capture_after got q=%b v=%b want q=1100011 v=1", bus7.out_q, bus7.out_valid);
    end
    @(negedge clk);
    bus7.en = 1'b0;
  endtask

  task automatic test_hold();
    @(negedge clk);
    bus7.en  = 1'b1;
    bus7.sel = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus7.out_q !== 7'b1000001) begin
      errors++;
      $display("FAIL hold_load got %b want %b", bus7.out_q, 7'b1000001);
    end
    @(negedge clk);
    bus7.en  = 1'b0;
    bus7.sel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus7.out_q !== 7'b1000001 || bus7.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_edge%0d got q=%b v=%b want q=1000001 v=1", k, bus7.out_q, bus7.out_valid);
      end
      checks++;
      if (bus7.out !== 7'b1100011) begin
        errors++;
        $display("FAIL hold_out%0d got %b want %b", k, bus7.out, 7'b1100011);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus7.en  = 1'b1;
    bus7.sel = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus7.out_q !== 7'b1100011) begin
      errors++;
      $display("FAIL areset_preload got %b want %b", bus7.out_q, 7'b1100011);
    end
    @(negedge clk);
    bus7.en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    // Still mid low-phase: no rising edge has occurred since rst rose.
    checks++;
    if (bus7.out_q !== 7'b0000000 || bus7.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_async got q=%b v=%b want q=0000000 v=0", bus7.out_q, bus7.out_valid);
    end
    @(negedge clk);
    bus7.en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus7.out_q !== 7'b0000000 || bus7.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_dominates got q=%b v=%b want q=0000000 v=0", bus7.out_q, bus7.out_valid);
    end
    @(negedge clk);
    rst     = 1'b0;
    bus7.en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus7.out_q !== 7'b0000000 || bus7.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_stays0 got q=%b v=%b want q=0000000 v=0", bus7.out_q, bus7.out_valid);
    end
    @(negedge clk);
    bus7.en  = 1'b1;
    bus7.sel = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus7.out_q !== 7'b1000001 || bus7.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_reload got q=%b v=%b want q=1000001 v=1", bus7.out_q, bus7.out_valid);
    end
    @(negedge clk);
    bus7.en = 1'b0;
  endtask

  task automatic test_width1();
    // Truth table indexed by {in0, in1, sel}.
    logic [7:0] tt;
    logic [2:0] idx;
    tt = 8'b11011000;
    for (int k = 0; k < 8; k++) begin
      idx      = 3'(k);
      bus1.in0 = idx[2];
      bus1.in1 = idx[1];
      bus1.sel = idx[0];
      #1;
      checks++;
      if (bus1.out !== tt[k]) begin
        errors++;
        $display("FAIL w1_tt in0=%b in1=%b sel=%b got %b want %b",
                 idx[2], idx[1], idx[0], bus1.out, tt[k]);
      end
    end
    bus1.in0 = 1'b1;
    bus1.in1 = 1'b1;
    bus1.sel = 1'bx;
    #1;
    checks++;
    if (bus1.out !== 1'b1) begin
      errors++;
      $display("FAIL w1_selx got %b want 1", bus1.out);
    end
    bus1.sel = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] ref_sel;
    logic         ref_valid;
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_q.delete();
    ref_valid = 1'b0;
    for (int n = 0; n < 220; n++) begin
      @(negedge clk);
      bus7.in0 = 7'($urandom_range(0, 127));
      bus7.in1 = 7'($urandom_range(0, 127));
      bus7.sel = 1'($urandom_range(0, 1));
      bus7.en  = ($urandom_range(0, 3) != 0);
      ref_sel  = bus7.sel ? bus7.in1 : bus7.in0;
      #1;
      checks++;
      if (bus7.out !== ref_sel) begin
        errors++;
        $display("FAIL rand_out n=%0d got %b want %b", n, bus7.out, ref_sel);
      end
      if (bus7.en) begin
        exp_q.push_back(ref_sel);
        ref_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus7.out_valid !== ref_valid) begin
        errors++;
        $display("FAIL rand_valid n=%0d got %b want %b", n, bus7.out_valid, ref_valid);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (bus7.out_q !== exp_q[$]) begin
          errors++;
          $display("FAIL rand_out_q n=%0d got %b want %b", n, bus7.out_q, exp_q[$]);
        end
      end else begin
        checks++;
        if (bus7.out_q !== 7'b0000000) begin
          errors++;
          $display("FAIL rand_out_q_idle n=%0d got %b want 0000000", n, bus7.out_q);
        end
      end
    end
    @(negedge clk);
    bus7.en = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_comb();
    test_capture();
    test_hold();
    test_async_reset();
    test_width1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_2to1
